// File: rtl/mem_wb_stage_pkg.sv
// Shared types for the MEM/WB back end: pipeline-register entries, the data-memory
// request bundle, the hazard feedback pairs and the memory-handshake FSM states.
package mem_wb_stage_pkg;

  typedef struct packed {
    logic        regWrite;
    logic        memRead;
    logic        memWrite;
    logic [4:0]  rd;
    logic [31:0] result;
    logic [31:0] s_data;
  } exmem_t;

  typedef struct packed {
    logic        regWrite;
    logic [4:0]  rd;
    logic [31:0] data;
  } memwb_t;

  typedef struct packed {
    logic        req;
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
  } dmem_req_t;

  // Destination-register feedback consumed by decode and forwarding.
  typedef struct packed {
    logic       exmem_regWrite;
    logic [4:0] exmem_rd;
    logic       memwb_regWrite;
    logic [4:0] memwb_rd;
  } rd_write_t;

  typedef enum logic {
    StRun,
    StWait
  } dmem_state_e;

  function automatic logic is_mem_op(input exmem_t e);
    return e.memRead | e.memWrite;
  endfunction

endpackage

// File: rtl/mem_wb_stage_if.sv
// Bus between the MEM/WB back end and its neighbours: EX inputs, data-memory
// handshake and the writeback/forwarding feedback.
interface mem_wb_stage_if;

  logic        ex_valid;
  logic [4:0]  ex_rd;
  logic        ex_regWrite;
  logic        ex_memRead;
  logic        ex_memWrite;
  logic [31:0] ex_result;
  logic [31:0] ex_s_data;

  logic        dm_req;
  logic        dm_we;
  logic [31:0] dm_addr;
  logic [31:0] dm_wdata;
  logic        dm_ack;
  logic [31:0] dm_rdata;

  logic        exmem_regWrite;
  logic [4:0]  exmem_rd;
  logic [31:0] exmem_result;
  logic        memwb_regWrite;
  logic [4:0]  memwb_rd;
  logic [31:0] wb_data;
  logic        mem_stall;
  logic        mem_err;

  // The stage itself.
  modport master (
    input  ex_valid, ex_rd, ex_regWrite, ex_memRead, ex_memWrite, ex_result, ex_s_data,
    input  dm_ack, dm_rdata,
    output dm_req, dm_we, dm_addr, dm_wdata,
    output exmem_regWrite, exmem_rd, exmem_result,
    output memwb_regWrite, memwb_rd, wb_data,
    output mem_stall, mem_err
  );

  // EX stage, data memory and the feedback consumers.
  modport slave (
    output ex_valid, ex_rd, ex_regWrite, ex_memRead, ex_memWrite, ex_result, ex_s_data,
    output dm_ack, dm_rdata,
    input  dm_req, dm_we, dm_addr, dm_wdata,
    input  exmem_regWrite, exmem_rd, exmem_result,
    input  memwb_regWrite, memwb_rd, wb_data,
    input  mem_stall, mem_err
  );

endinterface

// File: rtl/mem_wb_stage_dmem_if_fsm.sv
// Data-memory handshake controller: RUN/WAIT state, ack timeout counter, sticky
// error flag and the request/stall decode.
module mem_wb_stage_dmem_if_fsm
  import mem_wb_stage_pkg::*;
#(
  parameter int unsigned ACK_TIMEOUT = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic mem_op,
  input  logic dm_ack,
  output logic dm_req,
  output logic mem_stall,
  output logic timeout,
  output logic mem_err
);

  localparam int unsigned     CntW      = (ACK_TIMEOUT == 0) ? 1 : $clog2(ACK_TIMEOUT + 1);
  localparam logic [CntW-1:0] CntMax    = CntW'(ACK_TIMEOUT);
  localparam bit              TimeoutEn = (ACK_TIMEOUT != 0);

  dmem_state_e     state_q;
  logic [CntW-1:0] cnt_q;
  logic            err_q;

  // A late ack in the final cycle still wins over the timeout.
  always_comb begin
    timeout   = TimeoutEn && (state_q == StWait) && !dm_ack && (cnt_q == CntMax);
    dm_req    = mem_op && !timeout;
    mem_stall = dm_req && !dm_ack;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StRun;
      cnt_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      unique case (state_q)
        StRun: begin
          if (mem_op && !dm_ack) begin
            state_q <= StWait;
            cnt_q   <= CntW'(1);
          end
        end
        StWait: begin
          if (dm_ack) begin
            state_q <= StRun;
          end else if (timeout) begin
            state_q <= StRun;
            err_q   <= 1'b1;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        default: state_q <= StRun;
      endcase
    end
  end

  assign mem_err = err_q;

endmodule

// File: rtl/mem_wb_stage.sv
// Back end of the RV32 pipeline: EX/MEM and MEM/WB registers, data-memory access
// and the writeback/forwarding feedback.
module mem_wb_stage
  import mem_wb_stage_pkg::*;
#(
  parameter int unsigned ACK_TIMEOUT = 16
) (
  input logic            clk,
  input logic            rst,
  mem_wb_stage_if.master bus
);

  exmem_t    exmem_q, exmem_d;
  memwb_t    memwb_q, memwb_d;
  dmem_req_t dmem;
  rd_write_t fb;

  logic mem_op;
  logic dm_req;
  logic mem_stall;
  logic timeout;
  logic mem_err;

  assign mem_op = is_mem_op(exmem_q);

  mem_wb_stage_dmem_if_fsm #(
    .ACK_TIMEOUT(ACK_TIMEOUT)
  ) u_dmem_if_fsm (
    .clk      (clk),
    .rst      (rst),
    .mem_op   (mem_op),
    .dm_ack   (bus.dm_ack),
    .dm_req   (dm_req),
    .mem_stall(mem_stall),
    .timeout  (timeout),
    .mem_err  (mem_err)
  );

  always_comb begin
    exmem_d = exmem_q;
    if (!mem_stall) begin
      exmem_d.regWrite = bus.ex_valid & bus.ex_regWrite & (bus.ex_rd != 5'd0);
      exmem_d.memRead  = bus.ex_valid & bus.ex_memRead;
      exmem_d.memWrite = bus.ex_valid & bus.ex_memWrite;
      exmem_d.rd       = bus.ex_rd;
      exmem_d.result   = bus.ex_result;
      exmem_d.s_data   = bus.ex_s_data;
    end
  end

  // Stalled or abandoned accesses leave a bubble; rd and data keep their old values.
  always_comb begin
    memwb_d          = memwb_q;
    memwb_d.regWrite = 1'b0;
    if (!mem_stall && !timeout) begin
      memwb_d.regWrite = exmem_q.regWrite & ~exmem_q.memWrite;
      memwb_d.rd       = exmem_q.rd;
      memwb_d.data     = exmem_q.memRead ? bus.dm_rdata : exmem_q.result;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      exmem_q <= '0;
      memwb_q <= '0;
    end else begin
      exmem_q <= exmem_d;
      memwb_q <= memwb_d;
    end
  end

  always_comb begin
    dmem.req   = dm_req;
    dmem.we    = exmem_q.memWrite;
    dmem.addr  = exmem_q.result;
    dmem.wdata = exmem_q.s_data;

    fb.exmem_regWrite = exmem_q.regWrite;
    fb.exmem_rd       = exmem_q.rd;
    fb.memwb_regWrite = memwb_q.regWrite;
    fb.memwb_rd       = memwb_q.rd;
  end

  assign bus.dm_req         = dmem.req;
  assign bus.dm_we          = dmem.we;
  assign bus.dm_addr        = dmem.addr;
  assign bus.dm_wdata       = dmem.wdata;
  assign bus.exmem_regWrite = fb.exmem_regWrite;
  assign bus.exmem_rd       = fb.exmem_rd;
  assign bus.exmem_result   = exmem_q.result;
  assign bus.memwb_regWrite = fb.memwb_regWrite;
  assign bus.memwb_rd       = fb.memwb_rd;
  assign bus.wb_data        = memwb_q.data;
  assign bus.mem_stall      = mem_stall;
  assign bus.mem_err        = mem_err;

endmodule

// File: tb/tb_mem_wb_stage.sv
// Directed walk through the back-end scenarios, then random traffic against a
// transaction-level model of the stage.
module tb_mem_wb_stage;

  localparam int T = 4;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  mem_wb_stage_if bus ();

  mem_wb_stage #(
    .ACK_TIMEOUT(T)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  int compared   = 0;
  int mismatched = 0;

  // Model state: the instruction sitting in MEM, how long it has waited, the last
  // writeback and the error flag.
  logic        m_rw, m_mr, m_mw;
  logic [4:0]  m_rd;
  logic [31:0] m_res, m_sd;
  int          m_wait, lat;
  logic        m_wb_rw;
  logic [4:0]  m_wb_rd;
  logic [31:0] m_wb_data;
  logic        m_err;
  logic        is_mem, ack, exp_req, exp_stall;
  logic [31:0] rdata;
  logic        r_v, r_rw;
  int          r_kind;
  logic [4:0]  r_rd;
  logic [31:0] r_res, r_sd;

  task automatic chk1(input string tag, input logic obs, input logic exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  task automatic chk5(input string tag, input logic [4:0] obs, input logic [4:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic chk32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic chk_wb(input string tag, input logic rw, input logic [4:0] rd,
                        input logic [31:0] data);
    chk1({tag, "_memwb_regWrite"}, bus.memwb_regWrite, rw);
    chk5({tag, "_memwb_rd"}, bus.memwb_rd, rd);
    chk32({tag, "_wb_data"}, bus.wb_data, data);
  endtask

  task automatic chk_all_zero(input string tag);
    chk1({tag, "_dm_req"}, bus.dm_req, 1'b0);
    chk1({tag, "_dm_we"}, bus.dm_we, 1'b0);
    chk32({tag, "_dm_addr"}, bus.dm_addr, 32'h0);
    chk32({tag, "_dm_wdata"}, bus.dm_wdata, 32'h0);
    chk1({tag, "_mem_stall"}, bus.mem_stall, 1'b0);
    chk1({tag, "_exmem_regWrite"}, bus.exmem_regWrite, 1'b0);
    chk5({tag, "_exmem_rd"}, bus.exmem_rd, 5'd0);
    chk32({tag, "_exmem_result"}, bus.exmem_result, 32'h0);
    chk_wb(tag, 1'b0, 5'd0, 32'h0);
    chk1({tag, "_mem_err"}, bus.mem_err, 1'b0);
  endtask

  task automatic set_ex(input logic v, input logic [4:0] rd, input logic rw, input logic mr,
                        input logic mw, input logic [31:0] res, input logic [31:0] sd);
    assert (!(mr && mw)) else $fatal(1, "illegal load+store stimulus");
    bus.ex_valid    = v;
    bus.ex_rd       = rd;
    bus.ex_regWrite = rw;
    bus.ex_memRead  = mr;
    bus.ex_memWrite = mw;
    bus.ex_result   = res;
    bus.ex_s_data   = sd;
  endtask

  task automatic nop();
    set_ex(1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
  endtask

  task automatic mem_rsp(input logic a, input logic [31:0] d);
    bus.dm_ack   = a;
    bus.dm_rdata = d;
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic settle();
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation still running at %0t, required finish earlier", $time);
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst = 1'b1;
    nop();
    mem_rsp(1'b0, 32'h0);
    tick();
    tick();
    rst = 1'b0;
    settle();
    chk_all_zero("reset");

    // ADD rd=5
    set_ex(1'b1, 5'd5, 1'b1, 1'b0, 1'b0, 32'h0000_1234, 32'h0);
    settle();
    chk1("add_stall0", bus.mem_stall, 1'b0);
    tick();
    nop();
    settle();
    chk1("add_exmem_regWrite", bus.exmem_regWrite, 1'b1);
    chk5("add_exmem_rd", bus.exmem_rd, 5'd5);
    chk32("add_exmem_result", bus.exmem_result, 32'h0000_1234);
    chk1("add_stall1", bus.mem_stall, 1'b0);
    tick();
    settle();
    chk_wb("add_wb", 1'b1, 5'd5, 32'h0000_1234);
    chk1("add_stall2", bus.mem_stall, 1'b0);

    // LW rd=7 acked in its first cycle, followed immediately by LW rd=9
    set_ex(1'b1, 5'd7, 1'b1, 1'b1, 1'b0, 32'h40, 32'h0);
    tick();
    set_ex(1'b1, 5'd9, 1'b1, 1'b1, 1'b0, 32'h40, 32'h0);
    mem_rsp(1'b1, 32'hDEAD_BEEF);
    settle();
    chk1("lw0_req", bus.dm_req, 1'b1);
    chk1("lw0_we", bus.dm_we, 1'b0);
    chk32("lw0_addr", bus.dm_addr, 32'h40);
    chk1("lw0_stall", bus.mem_stall, 1'b0);
    tick();

    // LW rd=9 waits 3 cycles; ADD rd=10 is held upstream
    for (int i = 0; i < 3; i++) begin
      set_ex(1'b1, 5'd10, 1'b1, 1'b0, 1'b0, 32'h55, 32'h0);
      mem_rsp(1'b0, 32'h0);
      settle();
      chk1("lw3_stall", bus.mem_stall, 1'b1);
      chk1("lw3_req", bus.dm_req, 1'b1);
      chk32("lw3_addr", bus.dm_addr, 32'h40);
      if (i == 0) chk_wb("lw0_wb", 1'b1, 5'd7, 32'hDEAD_BEEF);
      else chk_wb("lw3_bubble", 1'b0, 5'd7, 32'hDEAD_BEEF);
      tick();
    end
    mem_rsp(1'b1, 32'hCAFE_F00D);
    settle();
    chk1("lw3_ack_stall", bus.mem_stall, 1'b0);
    chk1("lw3_ack_req", bus.dm_req, 1'b1);
    chk_wb("lw3_bubble3", 1'b0, 5'd7, 32'hDEAD_BEEF);
    tick();
    nop();
    mem_rsp(1'b0, 32'h0);
    settle();
    chk_wb("lw3_wb", 1'b1, 5'd9, 32'hCAFE_F00D);
    chk5("lw3_next_exmem_rd", bus.exmem_rd, 5'd10);
    chk1("lw3_next_exmem_rw", bus.exmem_regWrite, 1'b1);
    tick();
    settle();
    chk_wb("lw3_next_wb", 1'b1, 5'd10, 32'h55);

    // SW with regWrite set, then ADD to x0
    set_ex(1'b1, 5'd3, 1'b1, 1'b0, 1'b1, 32'h80, 32'h1111_2222);
    tick();
    set_ex(1'b1, 5'd0, 1'b1, 1'b0, 1'b0, 32'h99, 32'h0);
    mem_rsp(1'b1, 32'h1234_5678);
    settle();
    chk1("sw_req", bus.dm_req, 1'b1);
    chk1("sw_we", bus.dm_we, 1'b1);
    chk32("sw_addr", bus.dm_addr, 32'h80);
    chk32("sw_wdata", bus.dm_wdata, 32'h1111_2222);
    chk1("sw_stall", bus.mem_stall, 1'b0);
    tick();
    nop();
    mem_rsp(1'b0, 32'h0);
    settle();
    chk1("sw_memwb_rw", bus.memwb_regWrite, 1'b0);
    chk1("x0_exmem_rw", bus.exmem_regWrite, 1'b0);
    chk5("x0_exmem_rd", bus.exmem_rd, 5'd0);
    tick();
    settle();
    chk1("x0_memwb_rw", bus.memwb_regWrite, 1'b0);
    chk32("x0_wb_data", bus.wb_data, 32'h99);

    // LW rd=11 never acked: times out after T cycles
    set_ex(1'b1, 5'd11, 1'b1, 1'b1, 1'b0, 32'h100, 32'h0);
    tick();
    set_ex(1'b1, 5'd12, 1'b1, 1'b0, 1'b0, 32'h77, 32'h0);
    for (int i = 0; i < T; i++) begin
      settle();
      chk1("to_stall", bus.mem_stall, 1'b1);
      chk1("to_err_pre", bus.mem_err, 1'b0);
      tick();
    end
    settle();
    chk1("to_drop_stall", bus.mem_stall, 1'b0);
    chk1("to_drop_req", bus.dm_req, 1'b0);
    chk1("to_err_edge", bus.mem_err, 1'b0);
    tick();
    nop();
    settle();
    chk1("to_err", bus.mem_err, 1'b1);
    chk1("to_retire_rw", bus.memwb_regWrite, 1'b0);
    chk5("to_next_exmem_rd", bus.exmem_rd, 5'd12);
    chk1("to_next_exmem_rw", bus.exmem_regWrite, 1'b1);
    tick();
    settle();
    chk_wb("to_next_wb", 1'b1, 5'd12, 32'h77);
    chk1("to_err_sticky", bus.mem_err, 1'b1);

    // Reset while waiting on LW rd=13
    set_ex(1'b1, 5'd13, 1'b1, 1'b1, 1'b0, 32'h200, 32'h0);
    tick();
    nop();
    settle();
    chk1("rw_stall0", bus.mem_stall, 1'b1);
    tick();
    settle();
    chk1("rw_stall1", bus.mem_stall, 1'b1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    settle();
    chk_all_zero("rst_wait");
    set_ex(1'b1, 5'd14, 1'b1, 1'b1, 1'b0, 32'h40, 32'h0);
    tick();
    nop();
    mem_rsp(1'b1, 32'hA5A5_5A5A);
    settle();
    chk1("post_rst_stall", bus.mem_stall, 1'b0);
    tick();
    mem_rsp(1'b0, 32'h0);
    settle();
    chk_wb("post_rst_wb", 1'b1, 5'd14, 32'hA5A5_5A5A);
    chk1("post_rst_err", bus.mem_err, 1'b0);

    // Ack arriving in the timeout cycle is a success
    set_ex(1'b1, 5'd15, 1'b1, 1'b1, 1'b0, 32'h300, 32'h0);
    tick();
    nop();
    for (int i = 0; i < T; i++) begin
      settle();
      chk1("late_stall", bus.mem_stall, 1'b1);
      tick();
    end
    mem_rsp(1'b1, 32'h0BAD_F00D);
    settle();
    chk1("late_ack_stall", bus.mem_stall, 1'b0);
    chk1("late_ack_req", bus.dm_req, 1'b1);
    tick();
    mem_rsp(1'b0, 32'h0);
    settle();
    chk_wb("late_wb", 1'b1, 5'd15, 32'h0BAD_F00D);
    chk1("late_err", bus.mem_err, 1'b0);

    // Random traffic against the model
    rst = 1'b1;
    tick();
    rst = 1'b0;
    {m_rw, m_mr, m_mw, m_rd, m_res, m_sd} = '0;
    {m_wb_rw, m_wb_rd, m_wb_data, m_err} = '0;
    m_wait = 0;
    lat    = 0;
    for (int n = 0; n < 400; n++) begin
      r_v    = ($urandom_range(0, 3) != 0);
      r_kind = int'($urandom_range(0, 2));
      r_rd   = 5'($urandom_range(0, 31));
      r_rw   = ($urandom_range(0, 7) != 0);
      r_res  = $urandom();
      r_sd   = $urandom();
      set_ex(r_v, r_rd, r_rw, r_kind == 1, r_kind == 2, r_res, r_sd);

      is_mem = m_mr | m_mw;
      if (is_mem && m_wait == 0) lat = int'($urandom_range(0, T + 1));
      ack       = is_mem ? (m_wait == lat) : ($urandom_range(0, 3) == 0);
      rdata     = $urandom();
      mem_rsp(ack, rdata);
      exp_req   = is_mem && (ack || m_wait != T);
      exp_stall = exp_req && !ack;
      settle();

      chk1("r_req", bus.dm_req, exp_req);
      chk1("r_stall", bus.mem_stall, exp_stall);
      chk1("r_we", bus.dm_we, m_mw);
      chk32("r_addr", bus.dm_addr, m_res);
      chk32("r_wdata", bus.dm_wdata, m_sd);
      chk1("r_exmem_rw", bus.exmem_regWrite, m_rw);
      chk5("r_exmem_rd", bus.exmem_rd, m_rd);
      chk32("r_exmem_result", bus.exmem_result, m_res);
      chk_wb("r", m_wb_rw, m_wb_rd, m_wb_data);
      chk1("r_err", bus.mem_err, m_err);

      if (exp_stall) begin
        m_wb_rw = 1'b0;
        m_wait++;
      end else begin
        if (is_mem && !ack) begin
          m_err   = 1'b1;
          m_wb_rw = 1'b0;
        end else begin
          m_wb_rw   = m_rw && !m_mw;
          m_wb_rd   = m_rd;
          m_wb_data = m_mr ? rdata : m_res;
        end
        m_rw   = r_v && r_rw && (r_rd != 5'd0);
        m_mr   = r_v && (r_kind == 1);
        m_mw   = r_v && (r_kind == 2);
        m_rd   = r_rd;
        m_res  = r_res;
        m_sd   = r_sd;
        m_wait = 0;
      end
      tick();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
